// File: rtl/execute_muldiv_if.sv
// rtl/execute_muldiv_if.sv - decode/hazard/forward bus into the execute stage and its results out
interface execute_muldiv_if #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
);
  logic             StallE;
  logic             FlushE;
  logic             RegWriteD;
  logic             MemWriteD;
  logic             RegDstD;
  logic [1:0]       MemtoRegD;
  logic [1:0]       ALUSrcD;
  logic [2:0]       ALUControlD;
  logic [2:0]       MdOpD;
  logic [RADDR-1:0] RsD;
  logic [RADDR-1:0] RtD;
  logic [RADDR-1:0] RdD;
  logic [WIDTH-1:0] rd1D;
  logic [WIDTH-1:0] rd2D;
  logic [WIDTH-1:0] SignImmD;
  logic [WIDTH-1:0] UnsignedImmD;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic [WIDTH-1:0] ALUOutM;
  logic [WIDTH-1:0] ResultW;
  logic             RegWriteE;
  logic             MemWriteE;
  logic [1:0]       MemtoRegE;
  logic [RADDR-1:0] WriteRegE;
  logic [WIDTH-1:0] ExOutE;
  logic [WIDTH-1:0] WriteDataE;
  logic [RADDR-1:0] RsE;
  logic [RADDR-1:0] RtE;
  logic             MdBusyE;
  logic             MdStallE;

  modport master (
    output StallE, FlushE, RegWriteD, MemWriteD, RegDstD, MemtoRegD, ALUSrcD,
           ALUControlD, MdOpD, RsD, RtD, RdD, rd1D, rd2D, SignImmD, UnsignedImmD,
           ForwardAE, ForwardBE, ALUOutM, ResultW,
    input  RegWriteE, MemWriteE, MemtoRegE, WriteRegE, ExOutE, WriteDataE,
           RsE, RtE, MdBusyE, MdStallE
  );

  modport slave (
    input  StallE, FlushE, RegWriteD, MemWriteD, RegDstD, MemtoRegD, ALUSrcD,
           ALUControlD, MdOpD, RsD, RtD, RdD, rd1D, rd2D, SignImmD, UnsignedImmD,
           ForwardAE, ForwardBE, ALUOutM, ResultW,
    output RegWriteE, MemWriteE, MemtoRegE, WriteRegE, ExOutE, WriteDataE,
           RsE, RtE, MdBusyE, MdStallE
  );
endinterface

// File: rtl/execute_muldiv.sv
// rtl/execute_muldiv.sv - execute stage: ID/EX register, forwarding, ALU, iterative mul/div with HI/LO
module execute_muldiv #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input logic            clk,
  input logic            rst,
  execute_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef struct packed {
    logic             reg_write;
    logic             mem_write;
    logic             reg_dst;
    logic [1:0]       mem_to_reg;
    logic [1:0]       alu_src;
    logic [2:0]       alu_ctrl;
    logic [2:0]       md_op;
    logic [RADDR-1:0] rs;
    logic [RADDR-1:0] rt;
    logic [RADDR-1:0] rd;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] sign_imm;
    logic [WIDTH-1:0] uns_imm;
  } stage_t;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} md_state_t;

  stage_t           stage_q, stage_d;
  logic             load;
  logic [WIDTH-1:0] src_a, fwd_b, src_b, alu_y;

  md_state_t          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               issued_q, issued_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               md_req, issue, done, md_busy;

  logic               sgn, sa, sb;
  logic [WIDTH-1:0]   a_mag, b_mag, q_raw, r_raw;
  logic [WIDTH:0]     sum, trial;
  logic [2*WIDTH-1:0] mul_step, div_step, step, prod_fix;

  // Stage register input: flush loads a bubble, stall holds, otherwise capture decode
  always_comb begin
    stage_d = stage_q;
    load    = 1'b0;
    if (bus.FlushE) begin
      stage_d = '0;
      load    = 1'b1;
    end else if (!bus.StallE) begin
      stage_d.reg_write  = bus.RegWriteD;
      stage_d.mem_write  = bus.MemWriteD;
      stage_d.reg_dst    = bus.RegDstD;
      stage_d.mem_to_reg = bus.MemtoRegD;
      stage_d.alu_src    = bus.ALUSrcD;
      stage_d.alu_ctrl   = bus.ALUControlD;
      stage_d.md_op      = bus.MdOpD;
      stage_d.rs         = bus.RsD;
      stage_d.rt         = bus.RtD;
      stage_d.rd         = bus.RdD;
      stage_d.rd1        = bus.rd1D;
      stage_d.rd2        = bus.rd2D;
      stage_d.sign_imm   = bus.SignImmD;
      stage_d.uns_imm    = bus.UnsignedImmD;
      load               = 1'b1;
    end
  end

  // Stage register; reset also produces a bubble
  always_ff @(posedge clk) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  // Forwarding muxes and SrcB select
  always_comb begin
    case (bus.ForwardAE)
      2'b00:   src_a = stage_q.rd1;
      2'b01:   src_a = bus.ResultW;
      default: src_a = bus.ALUOutM;
    endcase
    case (bus.ForwardBE)
      2'b00:   fwd_b = stage_q.rd2;
      2'b01:   fwd_b = bus.ResultW;
      default: fwd_b = bus.ALUOutM;
    endcase
    case (stage_q.alu_src)
      2'b00:   src_b = fwd_b;
      2'b10:   src_b = stage_q.uns_imm;
      default: src_b = stage_q.sign_imm;
    endcase
  end

  // ALU; arithmetic wraps, 101 is unused and yields zero
  always_comb begin
    case (stage_q.alu_ctrl)
      3'b000:  alu_y = src_a & src_b;
      3'b001:  alu_y = src_a | src_b;
      3'b010:  alu_y = src_a + src_b;
      3'b011:  alu_y = src_a ^ src_b;
      3'b100:  alu_y = ~(src_a | src_b);
      3'b110:  alu_y = src_a - src_b;
      3'b111:  alu_y = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      default: alu_y = '0;
    endcase
  end

  assign md_req  = (stage_q.md_op >= 3'd1) && (stage_q.md_op <= 3'd4);
  assign issue   = md_req && (state_q == IDLE) && !issued_q;
  assign done    = (state_q == RUN) && (cnt_q == LAST);
  assign md_busy = (state_q == RUN);

  // MD state register; only reset aborts a running op
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // MD next state: WIDTH cycles in RUN per op
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (issue) state_d = RUN;
    end else if (cnt_q == LAST) begin
      state_d = IDLE;
    end
  end

  // MD outputs: busy flag and stall request for any MD or HI/LO access while busy
  always_comb begin
    bus.MdBusyE  = md_busy;
    bus.MdStallE = md_busy && (stage_q.md_op >= 3'd1) && (stage_q.md_op <= 3'd6);
  end

  // MD datapath: magnitude shift-add multiply / restoring divide, sign fix-up at the end
  always_comb begin
    sgn      = (stage_q.md_op == 3'd1) || (stage_q.md_op == 3'd3);
    sa       = sgn && src_a[WIDTH-1];
    sb       = sgn && fwd_b[WIDTH-1];
    a_mag    = sa ? -src_a : src_a;
    b_mag    = sb ? -fwd_b : fwd_b;
    sum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, b_q} : '0);
    mul_step = {sum, prod_q[WIDTH-1:1]};
    trial    = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]} - {1'b0, b_q};
    div_step = trial[WIDTH] ? {prod_q[2*WIDTH-2:0], 1'b0}
                            : {trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    step     = is_div_q ? div_step : mul_step;
    prod_fix = neg_q ? -step : step;
    q_raw    = step[WIDTH-1:0];
    r_raw    = step[2*WIDTH-1:WIDTH];

    cnt_d    = cnt_q;
    prod_d   = prod_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    // issued belongs to the op currently in E, so any register load clears it
    issued_d = load ? 1'b0 : (issue ? 1'b1 : issued_q);

    if (issue) begin
      prod_d   = {{WIDTH{1'b0}}, a_mag};
      b_d      = b_mag;
      is_div_d = stage_q.md_op >= 3'd3;
      neg_d    = sa ^ sb;
      rneg_d   = sa;
      cnt_d    = '0;
    end else if (state_q == RUN) begin
      prod_d = step;
      cnt_d  = cnt_q + CW'(1);
      if (done) begin
        if (is_div_q) begin
          // divide by zero: quotient all ones; remainder fix-up restores the dividend
          lo_d = (b_q == '0) ? '1 : (neg_q ? -q_raw : q_raw);
          hi_d = rneg_q ? -r_raw : r_raw;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
    end
  end

  // MD datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      issued_q <= 1'b0;
      prod_q   <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      issued_q <= issued_d;
      prod_q   <= prod_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.RegWriteE  = stage_q.reg_write;
  assign bus.MemWriteE  = stage_q.mem_write;
  assign bus.MemtoRegE  = stage_q.mem_to_reg;
  assign bus.WriteRegE  = stage_q.reg_dst ? stage_q.rd : stage_q.rt;
  assign bus.RsE        = stage_q.rs;
  assign bus.RtE        = stage_q.rt;
  assign bus.WriteDataE = fwd_b;
  assign bus.ExOutE     = (stage_q.md_op == 3'd5) ? hi_q :
                          (stage_q.md_op == 3'd6) ? lo_q : alu_y;
endmodule
